// File: rtl/timed_seq_pkg.sv
// Shared types and helpers for the timed phase sequencer.
package timed_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Next phase index, wrapping from the last phase back to 0.
    function automatic int unsigned next_phase_idx(input int unsigned cur,
                                                   input int unsigned n_phases);
        return (cur >= n_phases - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: clear, count-enable (hold when low), saturate at all-ones,
// and expiry compare against a duration limit where a limit of 0 behaves as 1.
module phase_timer
    import timed_seq_pkg::*;
#(
    parameter int T_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_clr,
    input  logic           i_inc,
    input  logic [T_W-1:0] i_limit,
    output logic [T_W-1:0] o_cnt,
    output logic           o_expire
);

    logic [T_W-1:0] r_cnt;
    logic [T_W-1:0] w_last;

    // >= rather than == so a limit lowered below the running count still expires.
    assign w_last   = (i_limit == '0) ? '0 : i_limit - T_W'(1);
    assign o_expire = (r_cnt >= w_last);
    assign o_cnt    = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + T_W'(1);
        end
    end

endmodule

// File: rtl/timed_phase_sequencer.sv
// Runtime-programmable N-phase timed sequencer with hold/skip and Mealy outputs.
// Define OUTPUT_REG_EN to register pattern and phase_done (one extra cycle of latency).
module timed_phase_sequencer
    import timed_seq_pkg::*;
#(
    parameter int               N_PHASES  = 4,
    parameter int               T_W       = 16,
    parameter int               OUT_W     = 3,
    parameter int               DEFAULT_T = 10,
    parameter logic [OUT_W-1:0] IDLE_PAT  = '0,
    localparam int              PH_W      = (N_PHASES > 1) ? $clog2(N_PHASES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             hold,
    input  logic             skip,
    input  logic             cfg_we,
    input  logic [PH_W-1:0]  cfg_addr,
    input  logic [T_W-1:0]   cfg_dur,
    input  logic [OUT_W-1:0] cfg_pat,
    output logic [PH_W-1:0]  phase,
    output logic [T_W-1:0]   t_cnt,
    output logic [OUT_W-1:0] pattern,
    output logic             phase_done
);

    state_t           r_state;
    state_t           w_state_next;
    logic [PH_W-1:0]  r_phase;
    logic [PH_W-1:0]  w_phase_next;

    logic [T_W-1:0]   w_dur_tbl [N_PHASES];
    logic [OUT_W-1:0] w_pat_tbl [N_PHASES];

    logic             w_adv;
    logic             w_clr;
    logic             w_inc;
    logic             w_expire;
    logic [T_W-1:0]   w_cnt;
    logic [T_W-1:0]   w_limit;
    logic [OUT_W-1:0] w_pattern;

    // One duration/pattern register pair per phase; out-of-range addresses match no entry.
    genvar gi;
    generate
        for (gi = 0; gi < N_PHASES; gi++) begin : g_tbl
            logic [T_W-1:0]   r_dur;
            logic [OUT_W-1:0] r_pat;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_dur <= T_W'(DEFAULT_T);
                    r_pat <= '0;
                end else if (cfg_we && (int'(cfg_addr) == gi)) begin
                    r_dur <= cfg_dur;
                    r_pat <= cfg_pat;
                end
            end

            assign w_dur_tbl[gi] = r_dur;
            assign w_pat_tbl[gi] = r_pat;
        end
    endgenerate

    assign w_limit = w_dur_tbl[r_phase];

    phase_timer #(
        .T_W(T_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .i_clr    (w_clr),
        .i_inc    (w_inc),
        .i_limit  (w_limit),
        .o_cnt    (w_cnt),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
        end
    end

    // Priority: en=0, then hold, then skip/expiry.
    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_clr        = 1'b0;
        w_inc        = 1'b0;
        w_adv        = (r_state == S_RUN) && en && !hold && (w_expire || skip);

        if (!en) begin
            w_state_next = S_IDLE;
            w_phase_next = '0;
            w_clr        = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_RUN;
                    w_phase_next = '0;
                    w_clr        = 1'b1;
                end
                S_RUN: begin
                    if (hold) begin
                        w_state_next = S_HOLD;
                    end else if (w_adv) begin
                        w_phase_next = PH_W'(next_phase_idx(32'(r_phase), N_PHASES));
                        w_clr        = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        w_state_next = S_RUN;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_phase_next = '0;
                    w_clr        = 1'b1;
                end
            endcase
        end

        w_pattern = ((r_state == S_RUN) || (r_state == S_HOLD)) ? w_pat_tbl[r_phase] : IDLE_PAT;
    end

    assign phase = r_phase;
    assign t_cnt = w_cnt;

`ifdef OUTPUT_REG_EN
    logic [OUT_W-1:0] r_pattern;
    logic             r_phase_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern    <= IDLE_PAT;
            r_phase_done <= 1'b0;
        end else begin
            r_pattern    <= w_pattern;
            r_phase_done <= w_adv;
        end
    end

    assign pattern    = r_pattern;
    assign phase_done = r_phase_done;
`else
    assign pattern    = w_pattern;
    assign phase_done = w_adv;
`endif

endmodule

// File: tb/tb_timed_phase_sequencer.sv
// Directed bench with a cycle-level reference model of the sequencer rules plus literal pins.
module tb_timed_phase_sequencer;

    localparam int B = 7;
`ifdef OUTPUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        reset;
    logic        en;
    logic        hold;
    logic        skip;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_dur;
    logic [2:0]  cfg_pat;
    logic [1:0]  phase;
    logic [15:0] t_cnt;
    logic [2:0]  pattern;
    logic        phase_done;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int m_mode;   // 0 idle, 1 run, 2 hold
    int m_phase;
    int m_t;
    int m_dur [4];
    int m_pat [4];
    int exp_pat_q;
    int exp_done_q;

    timed_phase_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .hold       (hold),
        .skip       (skip),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_dur    (cfg_dur),
        .cfg_pat    (cfg_pat),
        .phase      (phase),
        .t_cnt      (t_cnt),
        .pattern    (pattern),
        .phase_done (phase_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at time %0t", name, got, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_phase    = 0;
        m_t        = 0;
        exp_pat_q  = 0;
        exp_done_q = 0;
        for (int i = 0; i < 4; i++) begin
            m_dur[i] = 10;
            m_pat[i] = 0;
        end
    endtask

    // Check current outputs against the model, then advance the model by one clock.
    task automatic model_step();
        int eff;
        int adv;
        int pat_c;
        int e_pat;
        int e_done;
        if (!reset) begin
            model_reset();
            chk("mdl_rst_phase", int'(phase), 0);
            chk("mdl_rst_tcnt", int'(t_cnt), 0);
            chk("mdl_rst_pattern", int'(pattern), 0);
            chk("mdl_rst_done", int'(phase_done), 0);
            return;
        end
        eff   = (m_dur[m_phase] == 0) ? 1 : m_dur[m_phase];
        adv   = (m_mode == 1 && en && !hold && ((m_t >= eff - 1) || skip)) ? 1 : 0;
        pat_c = (m_mode == 0) ? 0 : m_pat[m_phase];
        e_pat  = (LAT == 1) ? exp_pat_q : pat_c;
        e_done = (LAT == 1) ? exp_done_q : adv;
        chk("mdl_phase", int'(phase), m_phase);
        chk("mdl_tcnt", int'(t_cnt), m_t);
        chk("mdl_pattern", int'(pattern), e_pat);
        chk("mdl_done", int'(phase_done), e_done);
        exp_pat_q  = pat_c;
        exp_done_q = adv;
        if (cfg_we && int'(cfg_addr) < 4) begin
            m_dur[int'(cfg_addr)] = int'(cfg_dur);
            m_pat[int'(cfg_addr)] = int'(cfg_pat);
        end
        if (!en) begin
            m_mode  = 0;
            m_phase = 0;
            m_t     = 0;
        end else begin
            case (m_mode)
                0: begin
                    m_mode  = 1;
                    m_phase = 0;
                    m_t     = 0;
                end
                1: begin
                    if (hold) m_mode = 2;
                    else if (adv != 0) begin
                        m_phase = (m_phase + 1) % 4;
                        m_t     = 0;
                    end else if (m_t < 65535) m_t = m_t + 1;
                end
                default: if (!hold) m_mode = 1;
            endcase
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            #4;
            model_step();
        end
    end

    task automatic wr(input int a, input int d, input int p);
        cfg_we   = 1'b1;
        cfg_addr = 2'(a);
        cfg_dur  = 16'(d);
        cfg_pat  = 3'(p);
    endtask

    initial begin
        int dur_i [4];
        int pat_i [4];
        int s2_ph [12];
        int s2_t [12];
        int s2_pat [12];
        int s2_done [12];
        int j;
        dur_i   = '{3, 1, 0, 5};
        pat_i   = '{1, 2, 4, 7};
        s2_ph   = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 3, 0};
        s2_t    = '{0, 0, 1, 2, 0, 0, 0, 1, 2, 3, 4, 0};
        s2_pat  = '{0, 1, 1, 1, 2, 4, 7, 7, 7, 7, 7, 1};
        s2_done = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0};

        reset = 1'b0; en = 1'b0; hold = 1'b0; skip = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_dur = '0; cfg_pat = '0;

        for (int k = 0; k < B + 71; k++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            hold   = 1'b0;
            skip   = 1'b0;
            reset  = !(k < 3 || k == B + 45);
            en     = (k >= B) && !(k == B + 60 || k == B + 61);
            if (k >= 3 && k < 7) wr(k - 3, dur_i[k - 3], pat_i[k - 3]);
            if (k >= B + 12 && k <= B + 15) begin
                hold = 1'b1;
                skip = 1'b1;
            end
            if (k == B + 19) skip = 1'b1;
            case (k)
                B + 13: wr(1, 5, 2);
                B + 21: wr(3, 20, 7);
                B + 30: wr(3, 4, 7);
                B + 32: wr(2, 10, 4);
                default: ;
            endcase
            #3;

            if (k == 1 || k == B + 45) begin
                chk("rst_phase", int'(phase), 0);
                chk("rst_tcnt", int'(t_cnt), 0);
                chk("rst_pattern", int'(pattern), 0);
                chk("rst_done", int'(phase_done), 0);
            end
            if (k >= B && k <= B + 11) begin
                j = k - B;
                chk("s2_phase", int'(phase), s2_ph[j]);
                chk("s2_tcnt", int'(t_cnt), s2_t[j]);
                chk("s2_pattern", int'(pattern), (j - LAT >= 0) ? s2_pat[j - LAT] : 0);
                chk("s2_done", int'(phase_done), (j - LAT >= 0) ? s2_done[j - LAT] : 0);
            end
            if (k == B + 17) chk("hold_tcnt_frozen", int'(t_cnt), 1);
            if (k == B + 18) chk("hold_resume_tcnt", int'(t_cnt), 2);
            if (k == B + 19 + LAT) chk("skip_done", int'(phase_done), 1);
            if (k == B + 20) chk("skip_next_phase", int'(phase), 2);
            if (k == B + 31) chk("shrink_tcnt", int'(t_cnt), 10);
            if (k == B + 31 + LAT) chk("shrink_done", int'(phase_done), 1);
            if (k == B + 32) chk("shrink_wrap_phase", int'(phase), 0);
            if (k == B + 50) chk("post_rst_pattern", int'(pattern), 0);
            if (k == B + 56) chk("default_dur_tcnt", int'(t_cnt), 9);
            if (k == B + 57) chk("default_dur_phase", int'(phase), 1);
            if (k == B + 61) chk("en_off_phase", int'(phase), 0);

            $display("cyc=%0d rst_n=%b en=%b hold=%b skip=%b we=%b ph=%0d t=%0d pat=%0d done=%b",
                     k, reset, en, hold, skip, cfg_we, phase, t_cnt, pattern, phase_done);
        end

        @(negedge clk);
        #6;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
